// File: rtl/lane_packer.sv
// lane_packer: packs a serial valid/ready sample stream into PAR_FACTOR-lane groups with flush of partial groups
module lane_packer #(
  parameter int PAR_FACTOR = 4,
  parameter int DATA_WIDTH = 4,
  localparam int CNT_WIDTH = $clog2(PAR_FACTOR + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data [PAR_FACTOR],
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  m_count,
  output logic                  busy
);
  typedef enum logic {FILL, FLUSH_WAIT} state_t;
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d, cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf_q [PAR_FACTOR];
  logic [DATA_WIDTH-1:0] buf_d [PAR_FACTOR];
  logic [DATA_WIDTH-1:0] out_q [PAR_FACTOR];
  logic [DATA_WIDTH-1:0] out_d [PAR_FACTOR];
  logic [DATA_WIDTH-1:0] grp [PAR_FACTOR];
  logic mv_q, mv_d, load_ok, acc, full, fl_req, emit;
  always_comb begin
    load_ok = !mv_q || m_ready;
    s_ready = !rst && state_q == FILL && !(idx_q == CNT_WIDTH'(PAR_FACTOR - 1) && !load_ok);
    acc = s_valid && s_ready;
    full = acc && idx_q == CNT_WIDTH'(PAR_FACTOR - 1);
    fl_req = state_q == FILL && flush && (idx_q != '0 || acc);
    // a pending or freshly requested partial group leaves only when the output register can take it
    emit = full || ((fl_req || state_q == FLUSH_WAIT) && load_ok);
    for (int i = 0; i < PAR_FACTOR; i++) grp[i] = (acc && idx_q == CNT_WIDTH'(i)) ? s_data : buf_q[i];
    for (int i = 0; i < PAR_FACTOR; i++) begin
      out_d[i] = emit ? grp[i] : out_q[i];
      buf_d[i] = emit ? '0 : grp[i];
    end
    cnt_d = emit ? (full ? CNT_WIDTH'(PAR_FACTOR) : idx_q + CNT_WIDTH'(acc)) : cnt_q;
    mv_d = emit || (mv_q && !m_ready);
    idx_d = emit ? '0 : idx_q + CNT_WIDTH'(acc);
    state_d = emit ? FILL : (fl_req ? FLUSH_WAIT : state_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q <= '0;
      cnt_q <= '0;
      mv_q <= 1'b0;
      for (int i = 0; i < PAR_FACTOR; i++) begin
        buf_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      mv_q <= mv_d;
      buf_q <= buf_d;
      out_q <= out_d;
    end
  end
  assign m_data = out_q;
  assign m_valid = mv_q;
  assign m_count = cnt_q;
  assign busy = idx_q != '0 || state_q == FLUSH_WAIT || mv_q;
endmodule

// File: tb/tb_lane_packer.sv
// tb_lane_packer: directed self-checking bench for lane_packer
module tb_lane_packer;
  logic clk = 0, rst = 1, s_valid = 0, flush = 0, m_ready = 0;
  logic [3:0] s_data = 0;
  logic s_ready, m_valid, busy;
  logic [3:0] m_data [4];
  logic [2:0] m_count;
  logic [15:0] md;
  int errs = 0, checks = 0;
  lane_packer dut (.clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .flush(flush), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_count(m_count), .busy(busy));
  always #5 clk = ~clk;
  assign md = {m_data[3], m_data[2], m_data[1], m_data[0]};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] d);
    s_valid = 1;
    s_data = d;
    step();
  endtask
  initial begin
    step();
    step();
    chk("rst_mv", m_valid, 0);
    chk("rst_cnt", m_count, 0);
    chk("rst_md", md, 0);
    chk("rst_busy", busy, 0);
    chk("rst_srdy", s_ready, 0);
    rst = 0;
    #1;
    chk("srdy_after_rst", s_ready, 1);
    m_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      s_valid = 1;
      s_data = 4'(k);
      #1;
      chk("full_srdy", s_ready, 1);
      step();
      if (k == 4) begin
        chk("g1_mv", m_valid, 1);
        chk("g1_md", md, 16'h4321);
        chk("g1_cnt", m_count, 4);
      end
      if (k == 5) chk("g1_drop", m_valid, 0);
      if (k == 8) begin
        chk("g2_mv", m_valid, 1);
        chk("g2_md", md, 16'h8765);
        chk("g2_cnt", m_count, 4);
      end
    end
    s_valid = 0;
    step();
    chk("g2_drop", m_valid, 0);
    chk("idle_busy", busy, 0);
    for (int k = 1; k <= 4; k++) send(4'(k));
    m_ready = 0;
    for (int k = 5; k <= 7; k++) begin
      s_data = 4'(k);
      #1;
      chk("bp_srdy", s_ready, 1);
      step();
      chk("bp_hold", md, 16'h4321);
    end
    s_data = 8;
    #1;
    chk("bp_stall", s_ready, 0);
    step();
    chk("bp_stall2", s_ready, 0);
    chk("bp_hold_mv", m_valid, 1);
    chk("bp_hold2", md, 16'h4321);
    m_ready = 1;
    #1;
    chk("bp_release", s_ready, 1);
    step();
    chk("bp_g2_md", md, 16'h8765);
    chk("bp_g2_mv", m_valid, 1);
    chk("bp_g2_cnt", m_count, 4);
    s_valid = 0;
    step();
    chk("bp_drop", m_valid, 0);
    send(4'h9);
    send(4'ha);
    s_valid = 0;
    flush = 1;
    step();
    flush = 0;
    chk("pf_mv", m_valid, 1);
    chk("pf_md", md, 16'h00a9);
    chk("pf_cnt", m_count, 2);
    step();
    chk("pf_drop", m_valid, 0);
    chk("pf_idx0", busy, 0);
    m_ready = 0;
    for (int k = 1; k <= 4; k++) send(4'(k));
    send(4'h3);
    s_data = 5;
    flush = 1;
    #1;
    chk("fw_srdy_in", s_ready, 1);
    step();
    flush = 0;
    s_valid = 0;
    chk("fw_srdy", s_ready, 0);
    chk("fw_busy", busy, 1);
    chk("fw_hold", md, 16'h4321);
    flush = 1;
    step();
    flush = 0;
    step();
    chk("fw_hold2", md, 16'h4321);
    m_ready = 1;
    step();
    chk("fw_md", md, 16'h0053);
    chk("fw_cnt", m_count, 2);
    chk("fw_mv", m_valid, 1);
    chk("fw_srdy_back", s_ready, 1);
    step();
    chk("fw_single", m_valid, 0);
    flush = 1;
    step();
    flush = 0;
    chk("ef_mv", m_valid, 0);
    chk("ef_busy", busy, 0);
    s_data = 6;
    s_valid = 1;
    flush = 1;
    step();
    flush = 0;
    s_valid = 0;
    chk("f1_md", md, 16'h0006);
    chk("f1_cnt", m_count, 1);
    for (int k = 1; k <= 3; k++) send(4'(k));
    s_data = 4;
    flush = 1;
    step();
    flush = 0;
    s_valid = 0;
    chk("ffull_md", md, 16'h4321);
    chk("ffull_cnt", m_count, 4);
    m_ready = 0;
    for (int k = 1; k <= 6; k++) send(4'(k));
    chk("pre_rst_mv", m_valid, 1);
    s_valid = 0;
    rst = 1;
    step();
    rst = 0;
    chk("mr_mv", m_valid, 0);
    chk("mr_cnt", m_count, 0);
    chk("mr_busy", busy, 0);
    chk("mr_md", md, 0);
    m_ready = 1;
    for (int k = 1; k <= 4; k++) send(4'h7);
    s_valid = 0;
    chk("mr_g_md", md, 16'h7777);
    chk("mr_g_cnt", m_count, 4);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
